// File: rtl/me_search_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | me_search_sched : motion-estimation block search scheduler, tracks the    |
// | minimum candidate SAD and its motion vector.        Revision 1.0          |
// +--------------------------------------------------------------------------+
module me_search_sched #(
  parameter int NUM_ROWS  = 64,
  parameter int NUM_COLS  = 64,
  parameter int CUR_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sad_valid,
  input  logic [17:0] sad32x32,
  output logic        busy,
  output logic        cur_load_en,
  output logic [3:0]  cur_rd_addr,
  output logic        begin_prepare,
  output logic [5:0]  search_row_count,
  output logic [5:0]  search_column_count,
  output logic        done,
  output logic [17:0] best_sad,
  output logic [6:0]  best_mv_x,
  output logic [6:0]  best_mv_y
);

  localparam logic [3:0] c_addr_last = 4'(CUR_BEATS - 1);
  localparam logic [5:0] c_row_last  = 6'(NUM_ROWS - 1);
  localparam logic [5:0] c_col_last  = 6'(NUM_COLS - 1);
  localparam logic [6:0] c_row_half  = 7'(NUM_ROWS / 2);
  localparam logic [6:0] c_col_half  = 7'(NUM_COLS / 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_CUR = 3'd1,
    S_PREP     = 3'd2,
    S_SEARCH   = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        cur_load_en_q, cur_load_en_d;
  logic        begin_prepare_q, begin_prepare_d;
  logic        done_q, done_d;
  logic [3:0]  addr_q, addr_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [17:0] min_sad_q, min_sad_d;
  logic [6:0]  min_mv_x_q, min_mv_x_d;
  logic [6:0]  min_mv_y_q, min_mv_y_d;
  logic        first_q, first_d;
  logic [17:0] best_sad_q, best_sad_d;
  logic [6:0]  best_mv_x_q, best_mv_x_d;
  logic [6:0]  best_mv_y_q, best_mv_y_d;

  logic [6:0]  w_cand_mv_x;
  logic [6:0]  w_cand_mv_y;
  logic        w_take;

  assign w_cand_mv_x = {1'b0, col_q} - c_col_half;
  assign w_cand_mv_y = {1'b0, row_q} - c_row_half;
  // first_q lets the opening candidate win even when its SAD equals the all-ones seed
  assign w_take      = first_q || (sad32x32 < min_sad_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    min_sad_d   = min_sad_q;
    min_mv_x_d  = min_mv_x_q;
    min_mv_y_d  = min_mv_y_q;
    first_d     = first_q;
    best_sad_d  = best_sad_q;
    best_mv_x_d = best_mv_x_q;
    best_mv_y_d = best_mv_y_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_LOAD_CUR;
          addr_d    = 4'd0;
          row_d     = 6'd0;
          col_d     = 6'd0;
          min_sad_d = '1;
          first_d   = 1'b1;
        end
      end
      S_LOAD_CUR: begin
        if (addr_q == c_addr_last) begin
          state_d = S_PREP;
        end else begin
          addr_d = addr_q + 4'd1;
        end
      end
      S_PREP: state_d = S_SEARCH;
      S_SEARCH: begin
        if (sad_valid) begin
          first_d = 1'b0;
          if (w_take) begin
            min_sad_d  = sad32x32;
            min_mv_x_d = w_cand_mv_x;
            min_mv_y_d = w_cand_mv_y;
          end
          if (col_q == c_col_last) begin
            col_d = 6'd0;
            if (row_q == c_row_last) begin
              // Publish on the edge that raises done, folding in this final candidate
              state_d     = S_FINISH;
              best_sad_d  = w_take ? sad32x32    : min_sad_q;
              best_mv_x_d = w_take ? w_cand_mv_x : min_mv_x_q;
              best_mv_y_d = w_take ? w_cand_mv_y : min_mv_y_q;
            end else begin
              row_d   = row_q + 6'd1;
              state_d = S_PREP;
            end
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      best_sad_d  = best_sad_q;
      best_mv_x_d = best_mv_x_q;
      best_mv_y_d = best_mv_y_q;
    end

    busy_d          = (state_d != S_IDLE);
    cur_load_en_d   = (state_d == S_LOAD_CUR);
    begin_prepare_d = (state_d == S_PREP);
    done_d          = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      cur_load_en_q   <= 1'b0;
      begin_prepare_q <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= 4'd0;
      row_q           <= 6'd0;
      col_q           <= 6'd0;
      min_sad_q       <= '1;
      min_mv_x_q      <= 7'd0;
      min_mv_y_q      <= 7'd0;
      first_q         <= 1'b0;
      best_sad_q      <= 18'd0;
      best_mv_x_q     <= 7'd0;
      best_mv_y_q     <= 7'd0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      cur_load_en_q   <= cur_load_en_d;
      begin_prepare_q <= begin_prepare_d;
      done_q          <= done_d;
      addr_q          <= addr_d;
      row_q           <= row_d;
      col_q           <= col_d;
      min_sad_q       <= min_sad_d;
      min_mv_x_q      <= min_mv_x_d;
      min_mv_y_q      <= min_mv_y_d;
      first_q         <= first_d;
      best_sad_q      <= best_sad_d;
      best_mv_x_q     <= best_mv_x_d;
      best_mv_y_q     <= best_mv_y_d;
    end
  end

  assign busy                = busy_q;
  assign cur_load_en         = cur_load_en_q;
  assign cur_rd_addr         = addr_q;
  assign begin_prepare       = begin_prepare_q;
  assign search_row_count    = row_q;
  assign search_column_count = col_q;
  assign done                = done_q;
  assign best_sad            = best_sad_q;
  assign best_mv_x           = best_mv_x_q;
  assign best_mv_y           = best_mv_y_q;

endmodule
`default_nettype wire

// File: doc/me_search_sched.md
ME_SEARCH_SCHED -- requirements
Module: me_search_sched

Interface
REQ-001 Parameter NUM_ROWS, 64, search rows per block (power of 2, 2..64).
REQ-002 Parameter NUM_COLS, 64, search candidates per row (power of 2, 2..64).
REQ-003 Parameter CUR_BEATS, 16, 512-bit current-block beats to load.
REQ-004 clk  in  1  single clock; one clock domain, all state on rising edge.
REQ-005 rst  in  1  reset is synchronous and active-high.
REQ-006 start  in  1  request one block search; sampled only in IDLE.
REQ-007 abort  in  1  cancel the search in progress.
REQ-008 sad_valid  in  1  sad32x32 holds one candidate SAD this cycle.
REQ-009 sad32x32  in  18  unsigned candidate SAD.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 cur_load_en  out  1  current-pixel beat enable for the PE array.
REQ-012 cur_rd_addr  out  4  current-block beat index.
REQ-013 begin_prepare  out  1  one-cycle start pulse to the PE array controller.
REQ-014 search_row_count  out  6  row being searched.
REQ-015 search_column_count  out  6  next candidate column within row.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 best_sad  out  18  minimum SAD of the last completed search.
REQ-018 best_mv_x, best_mv_y  out  7 each  signed two's-complement MV of best_sad.

Function
REQ-019 FSM states SHALL be IDLE, LOAD_CUR, PREP, SEARCH, FINISH.
REQ-020 IDLE: start=1 -> LOAD_CUR next cycle; clears row/column counts and sets internal min to all-ones.
REQ-021 LOAD_CUR: cur_load_en=1 for exactly CUR_BEATS consecutive cycles, cur_rd_addr 0..CUR_BEATS-1; after last beat -> PREP.
REQ-022 PREP: begin_prepare=1 for exactly this one cycle -> SEARCH.
REQ-023 SEARCH: each sad_valid=1 cycle consumes one candidate at (search_row_count, search_column_count), then column increments.
REQ-024 Candidate with column NUM_COLS-1 and row < NUM_ROWS-1: column wraps to 0, row increments, next state PREP (one begin_prepare per row).
REQ-025 Candidate at row NUM_ROWS-1, column NUM_COLS-1 -> FINISH.
REQ-026 Compare: candidate replaces minimum only if strictly less; ties keep earlier candidate; first candidate always wins over all-ones init.
REQ-027 MV of a candidate: mv_x = column - NUM_COLS/2, mv_y = row - NUM_ROWS/2.
REQ-028 FINISH: done=1 one cycle; best_sad/best_mv_* update from internal minimum on the same edge that raises done -> IDLE.
REQ-029 best_sad/best_mv_* SHALL hold stable from done until the next FINISH; unchanged by new start or abort.
REQ-030 sad_valid outside SEARCH SHALL be ignored; no count or minimum change.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort=1 in any non-IDLE state -> IDLE next cycle, no done, best outputs unchanged; abort has priority over all same-cycle transitions, including the final candidate.
REQ-033 abort in IDLE ignored; start and abort together in IDLE -> stay IDLE.
REQ-034 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-035 rst=1 at any edge, including mid-search: state IDLE; busy, cur_load_en, begin_prepare, done = 0; cur_rd_addr, counts, best_sad, best_mv_x, best_mv_y = 0; internal min = all-ones.
REQ-036 First start after rst release SHALL behave as REQ-020 with no residual state.

Verification (NUM_ROWS=2, NUM_COLS=4, CUR_BEATS=2)
REQ-037 start pulse -> busy next cycle; cur_load_en two cycles, addr 0,1; begin_prepare on third cycle after start.
REQ-038 SADs row0 {50,40,40,60}, row1 {70,30,90,30} -> done once, best_sad=30, best_mv_x=-1, best_mv_y=0; begin_prepare exactly twice.
REQ-039 sad_valid gapped (1 valid every 3 cycles) and valid during LOAD_CUR/PREP -> same results as contiguous; out-of-SEARCH valids ignored.
REQ-040 abort on final candidate cycle -> no done, busy low next cycle, best_* retain prior search values.
REQ-041 rst asserted during row1 SEARCH -> all outputs 0 next cycle; subsequent start with all SADs 100 -> best_sad=100, mv=(-2,-1).
REQ-042 start held high through FINISH -> second search begins only from IDLE, one cycle after done.
